// File: rtl/ecc_point_ctrl.sv
// ecc_point_ctrl: affine elliptic-curve point ADD/DBL sequencer driving an external GF(p) unit.
// Build macro ECC_CTRL_TIMEOUT_EN bounds every MUL/DIV wait to TIMEOUT_CYC cycles and enables err.
module ecc_point_ctrl #(
   parameter int SIZE = 32
`ifdef ECC_CTRL_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = 1024
`endif
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            start,
   input  logic            mode,
   input  logic [SIZE-1:0] x1,
   input  logic [SIZE-1:0] y1,
   input  logic [SIZE-1:0] x2,
   input  logic [SIZE-1:0] y2,
   input  logic [SIZE-1:0] a_coef,
   input  logic [SIZE-1:0] prime,
   output logic [SIZE-1:0] gf_in_0,
   output logic [SIZE-1:0] gf_in_1,
   output logic [1:0]      gf_op,
   output logic            gf_go,
   input  logic [SIZE-1:0] gf_result,
   input  logic            gf_done,
   output logic [SIZE-1:0] x3,
   output logic [SIZE-1:0] y3,
   output logic            inf,
   output logic            err,
   output logic            busy,
   output logic            done
);

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_FIN} state_t;

   localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;
   localparam logic [3:0] R_X1 = 4'd0, R_Y1 = 4'd1, R_X2 = 4'd2, R_Y2 = 4'd3, R_A  = 4'd4;
   localparam logic [3:0] R_T0 = 4'd5, R_T1 = 4'd6, R_L  = 4'd7, R_X3 = 4'd8, R_Y3 = 4'd9;

   // Microcode step = {op, src0, src1, dst}
   function automatic logic [13:0] rom(input logic dbl, input logic [3:0] pc);
      logic [13:0] w;
      w = 14'd0;
      if (dbl) begin
         case (pc)
            4'd0:    w = {OP_MUL, R_X1, R_X1, R_T0};
            4'd1:    w = {OP_ADD, R_T0, R_T0, R_T1};
            4'd2:    w = {OP_ADD, R_T1, R_T0, R_T0};
            4'd3:    w = {OP_ADD, R_T0, R_A,  R_T0};
            4'd4:    w = {OP_ADD, R_Y1, R_Y1, R_T1};
            4'd5:    w = {OP_DIV, R_T0, R_T1, R_L };
            4'd6:    w = {OP_MUL, R_L,  R_L,  R_T0};
            4'd7:    w = {OP_SUB, R_T0, R_X1, R_T0};
            4'd8:    w = {OP_SUB, R_T0, R_X1, R_X3};
            4'd9:    w = {OP_SUB, R_X1, R_X3, R_T0};
            4'd10:   w = {OP_MUL, R_L,  R_T0, R_T0};
            4'd11:   w = {OP_SUB, R_T0, R_Y1, R_Y3};
            default: w = 14'd0;
         endcase
      end else begin
         case (pc)
            4'd0:    w = {OP_SUB, R_Y2, R_Y1, R_T0};
            4'd1:    w = {OP_SUB, R_X2, R_X1, R_T1};
            4'd2:    w = {OP_DIV, R_T0, R_T1, R_L };
            4'd3:    w = {OP_MUL, R_L,  R_L,  R_T0};
            4'd4:    w = {OP_SUB, R_T0, R_X1, R_T0};
            4'd5:    w = {OP_SUB, R_T0, R_X2, R_X3};
            4'd6:    w = {OP_SUB, R_X1, R_X3, R_T0};
            4'd7:    w = {OP_MUL, R_L,  R_T0, R_T0};
            4'd8:    w = {OP_SUB, R_T0, R_Y1, R_Y3};
            default: w = 14'd0;
         endcase
      end
      return w;
   endfunction

   state_t          state_r, state_nx;
   logic [3:0]      pc_r, pc_nx;
   logic            dbl_r, dbl_nx, gap_r, gap_nx;
   logic            load_s, wr_en_s, clr_res_s, inf_set_s, err_set_s, to_s;
   logic [13:0]     step_s, next_step_s;
   logic            last_s, x_eq_s, y_eq_s, pt_inf_s;
   logic [SIZE-1:0] rf_r [0:9];
   logic            gf_go_r, busy_r, done_r, inf_r, err_r;
   logic            unused_s;

   assign step_s      = rom(dbl_r, pc_r);
   assign next_step_s = rom(dbl_r, pc_r + 4'd1);
   assign last_s      = dbl_r ? (pc_r == 4'd11) : (pc_r == 4'd8);
   assign x_eq_s      = (rf_r[R_X1] == rf_r[R_X2]);
   assign y_eq_s      = (rf_r[R_Y1] == rf_r[R_Y2]);
   // P == Q falls through to doubling, so a zero y1 there is also the point at infinity
   assign pt_inf_s    = (!dbl_r && x_eq_s && !y_eq_s) ||
                        ((dbl_r || (x_eq_s && y_eq_s)) && (rf_r[R_Y1] == {SIZE{1'b0}}));
   assign unused_s    = ^{prime, next_step_s[12:0]};

`ifdef ECC_CTRL_TIMEOUT_EN
   logic [SIZE-1:0] wcnt_r;

   // Wait counter: restarts on every issue, counts cycles spent in WAIT
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)
         wcnt_r <= {SIZE{1'b0}};
      else if (state_r == S_ISSUE)
         wcnt_r <= {SIZE{1'b0}};
      else if (state_r == S_WAIT)
         wcnt_r <= wcnt_r + {{(SIZE-1){1'b0}}, 1'b1};
   end

   assign to_s = (wcnt_r == SIZE'(TIMEOUT_CYC - 1));
`else
   assign to_s = 1'b0;
`endif

   // FSM state and sequencing registers
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_r <= S_IDLE;
         pc_r    <= 4'd0;
         dbl_r   <= 1'b0;
         gap_r   <= 1'b0;
      end else begin
         state_r <= state_nx;
         pc_r    <= pc_nx;
         dbl_r   <= dbl_nx;
         gap_r   <= gap_nx;
      end
   end

   // Next-state, program counter and register-file write decisions
   always_comb begin
      state_nx  = state_r;
      pc_nx     = pc_r;
      dbl_nx    = dbl_r;
      gap_nx    = gap_r;
      load_s    = 1'b0;
      wr_en_s   = 1'b0;
      clr_res_s = 1'b0;
      inf_set_s = 1'b0;
      err_set_s = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               load_s   = 1'b1;
               dbl_nx   = mode;
               pc_nx    = 4'd0;
               gap_nx   = 1'b0;
               state_nx = S_CHECK;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_CHECK: begin
            if (pt_inf_s) begin
               inf_set_s = 1'b1;
               clr_res_s = 1'b1;
               state_nx  = S_FIN;
            end else begin
               dbl_nx   = dbl_r | (x_eq_s & y_eq_s);
               state_nx = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (gap_r) begin
               gap_nx = 1'b0;
            end else if (step_s[13]) begin
               state_nx = S_WAIT;
            end else begin
               wr_en_s = 1'b1;
               if (last_s)
                  state_nx = S_FIN;
               else
                  pc_nx = pc_r + 4'd1;
            end
         end
         S_WAIT: begin
            if (gf_done) begin
               wr_en_s = 1'b1;
               if (last_s) begin
                  state_nx = S_FIN;
               end else begin
                  pc_nx    = pc_r + 4'd1;
                  gap_nx   = next_step_s[13];
                  state_nx = S_ISSUE;
               end
            end else if (to_s) begin
               err_set_s = 1'b1;
               clr_res_s = 1'b1;
               state_nx  = S_FIN;
            end else begin
               state_nx = S_WAIT;
            end
         end
         S_FIN:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Output flags, registered from the next state so they line up with it
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         gf_go_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         inf_r   <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         gf_go_r <= ((state_nx == S_ISSUE) && !gap_nx) || (state_nx == S_WAIT);
         busy_r  <= (state_nx == S_CHECK) || (state_nx == S_ISSUE) || (state_nx == S_WAIT);
         done_r  <= (state_nx == S_FIN);
         if (load_s)
            inf_r <= 1'b0;
         else if (inf_set_s)
            inf_r <= 1'b1;
         if (load_s)
            err_r <= 1'b0;
         else if (err_set_s)
            err_r <= 1'b1;
      end
   end

   // Register file: captured operands, temporaries and the result point
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int i = 0; i < 10; i++)
            rf_r[i] <= {SIZE{1'b0}};
      end else if (load_s) begin
         rf_r[R_X1] <= x1;
         rf_r[R_Y1] <= y1;
         rf_r[R_X2] <= x2;
         rf_r[R_Y2] <= y2;
         rf_r[R_A]  <= a_coef;
      end else if (clr_res_s) begin
         rf_r[R_X3] <= {SIZE{1'b0}};
         rf_r[R_Y3] <= {SIZE{1'b0}};
      end else if (wr_en_s) begin
         rf_r[step_s[3:0]] <= gf_result;
      end
   end

   assign gf_go   = gf_go_r;
   assign gf_op   = gf_go_r ? step_s[13:12] : 2'd0;
   assign gf_in_0 = gf_go_r ? rf_r[step_s[11:8]] : {SIZE{1'b0}};
   assign gf_in_1 = gf_go_r ? rf_r[step_s[7:4]]  : {SIZE{1'b0}};
   assign x3      = rf_r[R_X3];
   assign y3      = rf_r[R_Y3];
   assign inf     = inf_r;
   assign err     = err_r;
   assign busy    = busy_r;
   assign done    = done_r;

endmodule
